// File: rtl/kyber_pkg.sv
// Shared types and modular helpers for the Baby-Kyber encryption core.
// Helpers take the modulus as an argument so parametrised instances can reuse them.
package kyber_pkg;

    localparam int KYBER_Q     = 17;
    localparam int KYBER_QHALF = (KYBER_Q + 1) / 2;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_t;

    function automatic int mod_add(input int a, input int b, input int q);
        return (a + b) % q;
    endfunction

    // Subtraction is folded into an addition of the complement so it never goes negative.
    function automatic int mod_sub(input int a, input int b, input int q);
        return (a + (q - b)) % q;
    endfunction

    function automatic int mod_mul(input int a, input int b, input int q);
        return (a * b) % q;
    endfunction

endpackage

// File: rtl/poly_mac_unit.sv
// Single modular multiply-accumulate step: res = (acc +/- a*b) mod Q.
// Purely combinational; the caller owns the accumulator register.
module poly_mac_unit
    import kyber_pkg::*;
#(
    parameter int Q      = KYBER_Q,
    parameter int COEF_W = 5
) (
    input  logic [COEF_W-1:0] acc,
    input  logic [COEF_W-1:0] a,
    input  logic [COEF_W-1:0] b,
    input  logic              neg,
    output logic [COEF_W-1:0] res
);

    int prod_red;

    always_comb begin
        prod_red = mod_mul(int'(a), int'(b), Q);
        if (neg) begin
            res = COEF_W'(mod_sub(int'(acc), prod_red, Q));
        end else begin
            res = COEF_W'(mod_add(int'(acc), prod_red, Q));
        end
    end

endmodule

// File: rtl/kyber_encrypt_seq.sv
// Sequential Baby-Kyber encryption: u = A^T*r + e1, v = t^T*r + e2 + Decompress(m).
// One negacyclic modular MAC per cycle through a single shared poly_mac_unit.
module kyber_encrypt_seq
    import kyber_pkg::*;
#(
    parameter int K      = 2,
    parameter int N      = 4,
    parameter int Q      = KYBER_Q,
    parameter int COEF_W = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [K*K*N*COEF_W-1:0]    a_mat,
    input  logic [K*N*COEF_W-1:0]      t_vec,
    input  logic [K*N*COEF_W-1:0]      r_vec,
    input  logic [K*N*COEF_W-1:0]      e1_vec,
    input  logic [N*COEF_W-1:0]        e2_poly,
    input  logic [N-1:0]               message,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [K*N*COEF_W-1:0]      u_vec,
    output logic [N*COEF_W-1:0]        v_poly
);

    localparam int QHALF = (Q == KYBER_Q) ? KYBER_QHALF : (Q + 1) / 2;
    localparam int RW    = $clog2(K + 1);
    localparam int KW    = (K > 1) ? $clog2(K) : 1;
    localparam int NW    = (N > 1) ? $clog2(N) : 1;

    state_t state, state_nxt;

    logic [RW-1:0] ro;
    logic [NW-1:0] ci;
    logic [KW-1:0] ck;
    logic [NW-1:0] cj;

    logic [K*K*N*COEF_W-1:0] a_r;
    logic [K*N*COEF_W-1:0]   t_r;
    logic [K*N*COEF_W-1:0]   r_r;
    logic [K*N*COEF_W-1:0]   u_r;
    logic [N*COEF_W-1:0]     v_r;
    logic [N*COEF_W-1:0]     v_init;
    logic                    out_valid_r;

    logic accept, mac_en, last_term, dest_is_u;
    logic [COEF_W-1:0] mac_acc, mac_a, mac_b, mac_res;
    logic              mac_neg;
    int                idx;

    assign accept    = in_valid && in_ready;
    assign dest_is_u = (int'(ro) < K);
    assign last_term = mac_en && (ro == RW'(K)) && (ci == NW'(N - 1))
                       && (ck == KW'(K - 1)) && (cj == NW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = MAC;
            MAC:     if (last_term) state_nxt = DONE;
            DONE:    if (out_valid_r && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
        mac_en   = (state == MAC);
    end

    // out_valid is registered, so it rises one cycle after DONE is entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
        end else if (state == DONE && !out_valid_r) begin
            out_valid_r <= 1'b1;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Loop nest, outer to inner: ro, ci, ck, cj
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ro <= '0;
            ci <= '0;
            ck <= '0;
            cj <= '0;
        end else if (accept) begin
            ro <= '0;
            ci <= '0;
            ck <= '0;
            cj <= '0;
        end else if (mac_en) begin
            if (cj == NW'(N - 1)) begin
                cj <= '0;
                if (ck == KW'(K - 1)) begin
                    ck <= '0;
                    if (ci == NW'(N - 1)) begin
                        ci <= '0;
                        ro <= (ro == RW'(K)) ? '0 : ro + 1'b1;
                    end else begin
                        ci <= ci + 1'b1;
                    end
                end else begin
                    ck <= ck + 1'b1;
                end
            end else begin
                cj <= cj + 1'b1;
            end
        end
    end

    always_comb begin
        v_init = '0;
        for (int i = 0; i < N; i++) begin
            v_init[i*COEF_W +: COEF_W] = COEF_W'(mod_add(int'(e2_poly[i*COEF_W +: COEF_W]),
                                                         message[i] ? QHALF : 0, Q));
        end
    end

    // Operand fetch: A is read transposed for u rows, t for the v row
    always_comb begin
        idx = (int'(ci) >= int'(cj)) ? int'(ci) - int'(cj) : int'(ci) + N - int'(cj);
        mac_neg = (cj > ci);
        mac_b   = r_r[(int'(ck) * N + idx) * COEF_W +: COEF_W];
        if (dest_is_u) begin
            mac_a   = a_r[((int'(ck) * K + int'(ro)) * N + int'(cj)) * COEF_W +: COEF_W];
            mac_acc = u_r[(int'(ro) * N + int'(ci)) * COEF_W +: COEF_W];
        end else begin
            mac_a   = t_r[(int'(ck) * N + int'(cj)) * COEF_W +: COEF_W];
            mac_acc = v_r[int'(ci) * COEF_W +: COEF_W];
        end
    end

    poly_mac_unit #(
        .Q      (Q),
        .COEF_W (COEF_W)
    ) u_mac (
        .acc (mac_acc),
        .a   (mac_a),
        .b   (mac_b),
        .neg (mac_neg),
        .res (mac_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= '0;
            t_r <= '0;
            r_r <= '0;
            u_r <= '0;
            v_r <= '0;
        end else if (accept) begin
            a_r <= a_mat;
            t_r <= t_vec;
            r_r <= r_vec;
            u_r <= e1_vec;
            v_r <= v_init;
        end else if (mac_en) begin
            if (dest_is_u) begin
                u_r[(int'(ro) * N + int'(ci)) * COEF_W +: COEF_W] <= mac_res;
            end else begin
                v_r[int'(ci) * COEF_W +: COEF_W] <= mac_res;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign u_vec     = u_r;
    assign v_poly    = v_r;

endmodule

// File: tb/tb_kyber_encrypt_seq.sv
// Directed and random checks of kyber_encrypt_seq at K=2, N=4, Q=17.
module tb_kyber_encrypt_seq;

    localparam int K = 2;
    localparam int N = 4;
    localparam int Q = 17;
    localparam int W = 5;
    localparam int LAT = (K + 1) * K * N * N + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid;
    logic [K*K*N*W-1:0] a_mat = '0;
    logic [K*N*W-1:0]   t_vec = '0;
    logic [K*N*W-1:0]   r_vec = '0;
    logic [K*N*W-1:0]   e1_vec = '0;
    logic [N*W-1:0]     e2_poly = '0;
    logic [N-1:0]       message = '0;
    logic [K*N*W-1:0]   u_vec;
    logic [N*W-1:0]     v_poly;

    int A [K*K][N];
    int T [K][N];
    int R [K][N];
    int E1[K][N];
    int E2[N];
    logic [K*N*W-1:0] exp_u;
    logic [N*W-1:0]   exp_v;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    kyber_encrypt_seq #(.K(K), .N(N), .Q(Q), .COEF_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_mat     (a_mat),
        .t_vec     (t_vec),
        .r_vec     (r_vec),
        .e1_vec    (e1_vec),
        .e2_poly   (e2_poly),
        .message   (message),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .u_vec     (u_vec),
        .v_poly    (v_poly)
    );

    task automatic clear_operands();
        for (int p = 0; p < K*K; p++) for (int c = 0; c < N; c++) A[p][c] = 0;
        for (int p = 0; p < K; p++) for (int c = 0; c < N; c++) begin
            T[p][c] = 0; R[p][c] = 0; E1[p][c] = 0;
        end
        for (int c = 0; c < N; c++) E2[c] = 0;
        message = '0;
    endtask

    task automatic pack_inputs();
        for (int p = 0; p < K*K; p++) for (int c = 0; c < N; c++)
            a_mat[(p*N+c)*W +: W] = W'(A[p][c]);
        for (int p = 0; p < K; p++) for (int c = 0; c < N; c++) begin
            t_vec[(p*N+c)*W +: W]  = W'(T[p][c]);
            r_vec[(p*N+c)*W +: W]  = W'(R[p][c]);
            e1_vec[(p*N+c)*W +: W] = W'(E1[p][c]);
        end
        for (int c = 0; c < N; c++) e2_poly[c*W +: W] = W'(E2[c]);
    endtask

    // Reference: full schoolbook product, then fold x^N = -1.
    task automatic model();
        int acc[N];
        int c[2*N];
        int val;
        for (int ro = 0; ro <= K; ro++) begin
            for (int i = 0; i < N; i++)
                acc[i] = (ro < K) ? E1[ro][i] : E2[i] + (message[i] ? (Q + 1) / 2 : 0);
            for (int k = 0; k < K; k++) begin
                for (int n = 0; n < 2*N; n++) c[n] = 0;
                for (int j = 0; j < N; j++) for (int m = 0; m < N; m++)
                    c[j+m] += ((ro < K) ? A[k*K+ro][j] : T[k][j]) * R[k][m];
                for (int i = 0; i < N; i++) acc[i] += c[i] - c[i+N];
            end
            for (int i = 0; i < N; i++) begin
                val = ((acc[i] % Q) + Q) % Q;
                if (ro < K) exp_u[(ro*N+i)*W +: W] = W'(val);
                else        exp_v[i*W +: W] = W'(val);
            end
        end
    endtask

    // Accepts the packed bundle and waits for out_valid without releasing it.
    task automatic start_and_wait(input string name);
        int lat;
        pack_inputs();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 1000) begin
            @(posedge clk); #1;
            lat++;
        end
        n_vec++;
        if (lat !== LAT) begin
            n_err++;
            $display("FAIL %s latency got %0d want %0d", name, lat, LAT);
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic check_uv(input string name, input logic [K*N*W-1:0] eu,
                            input logic [N*W-1:0] ev);
        n_vec++;
        if (u_vec !== eu) begin
            n_err++;
            $display("FAIL %s u_vec got %h want %h", name, u_vec, eu);
        end
        n_vec++;
        if (v_poly !== ev) begin
            n_err++;
            $display("FAIL %s v_poly got %h want %h", name, v_poly, ev);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl in_ready/out_valid got %b%b want 10", in_ready, out_valid);
        end
        check_uv("reset_data", '0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stray_out_ready in_ready/out_valid got %b%b want 10", in_ready, out_valid);
        end
    endtask

    task automatic test_zero_msg();
        clear_operands();
        message = 4'b1011;
        start_and_wait("zero_msg");
        check_uv("zero_msg", '0, {5'd9, 5'd0, 5'd9, 5'd9});
        release_out();
    endtask

    task automatic test_identity();
        clear_operands();
        A[0] = '{1, 0, 0, 0};
        R[0] = '{1, 2, 3, 4};
        start_and_wait("identity");
        check_uv("identity", {20'd0, 5'd4, 5'd3, 5'd2, 5'd1}, '0);
        release_out();
    endtask

    task automatic load_wrap();
        clear_operands();
        A[0] = '{0, 1, 0, 0};
        R[0] = '{1, 2, 3, 4};
    endtask

    task automatic test_wrap();
        load_wrap();
        start_and_wait("wrap");
        check_uv("wrap", {20'd0, 5'd3, 5'd2, 5'd1, 5'd13}, '0);
        release_out();
    endtask

    task automatic test_noise_wrap();
        clear_operands();
        E2 = '{16, 16, 16, 16};
        message = 4'b0001;
        start_and_wait("noise_wrap");
        check_uv("noise_wrap", '0, {5'd16, 5'd16, 5'd16, 5'd8});
        release_out();
    endtask

    task automatic test_back_to_back_backpressure();
        logic [K*N*W-1:0] wu;
        wu = {20'd0, 5'd3, 5'd2, 5'd1, 5'd13};
        load_wrap();
        start_and_wait("backpressure");
        clear_operands();
        A[0] = '{5, 5, 5, 5};
        message = 4'b1111;
        pack_inputs();
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            n_vec++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold cycle %0d out_valid/in_ready got %b%b want 10",
                         c, out_valid, in_ready);
            end
            check_uv("bp_hold", wu, '0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_release in_ready/out_valid got %b%b want 10", in_ready, out_valid);
        end
        @(posedge clk); #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_no_accept in_ready got %b want 1", in_ready);
        end
        check_uv("bp_held", wu, '0);
    endtask

    task automatic test_reset_mid();
        load_wrap();
        pack_inputs();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset out_valid/in_ready got %b%b want 01", out_valid, in_ready);
        end
        check_uv("mid_reset", '0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_and_wait("rerun");
        check_uv("rerun", {20'd0, 5'd3, 5'd2, 5'd1, 5'd13}, '0);
        release_out();
    endtask

    task automatic test_random();
        for (int b = 0; b < 150; b++) begin
            for (int p = 0; p < K*K; p++) for (int c = 0; c < N; c++)
                A[p][c] = int'($urandom_range(Q - 1, 0));
            for (int p = 0; p < K; p++) for (int c = 0; c < N; c++) begin
                T[p][c]  = int'($urandom_range(Q - 1, 0));
                R[p][c]  = int'($urandom_range(Q - 1, 0));
                E1[p][c] = int'($urandom_range(Q - 1, 0));
            end
            for (int c = 0; c < N; c++) E2[c] = int'($urandom_range(Q - 1, 0));
            message = N'($urandom_range(15, 0));
            model();
            start_and_wait("random");
            check_uv("random", exp_u, exp_v);
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_zero_msg();
        test_identity();
        test_wrap();
        test_noise_wrap();
        test_back_to_back_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
